// File: rtl/lr35902_oam_multi_if.sv
// CPU-side bus of the parametrised PPU object attribute memory.
// The CPU/bus-decoder side drives through the master modport; the OAM uses the slave modport.
interface lr35902_oam_multi_if #(
  parameter int ADR_W = 8,
  parameter int LANES = 2
);
  logic [ADR_W-1:0]   adr;
  logic [7:0]         din;
  logic               read;
  logic               write;
  logic [7:0]         dout;
  logic [LANES*8-1:0] dout_wide;
  logic               busy;

  modport master (output adr, din, read, write, input dout, dout_wide, busy);
  modport slave  (input adr, din, read, write, output dout, dout_wide, busy);
endinterface

// File: rtl/lr35902_oam_multi.sv
// Parametrised object attribute memory for the PPU sprite fetcher.
// CPU byte read/write, LANES-byte wide registered read, and a clear sequencer
// that zeroes the RAM after every reset.
// Optional OAM DMA engine: define LR35902_OAM_DMA_EN to add dma_start/dma_adr/dma_din.
module lr35902_oam_multi #(
  parameter int ENTRIES     = 40,
  parameter int ENTRY_BYTES = 4,
  parameter int LANES       = 2,
  parameter int ADR_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
`ifdef LR35902_OAM_DMA_EN
  input  logic             dma_start,
  output logic [ADR_W-1:0] dma_adr,
  input  logic [7:0]       dma_din,
`endif
  lr35902_oam_multi_if.slave bus
);

  localparam int TOTAL  = ENTRIES * ENTRY_BYTES;
  localparam int WORDS  = TOTAL / LANES;
  localparam int WORD_W = LANES * 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  // One extra bit so TOTAL == 2**ADR_W still compares correctly.
  localparam logic [ADR_W:0]   TOTAL_C   = (ADR_W+1)'(TOTAL);
  localparam logic [ADR_W-1:0] LAST_WORD = ADR_W'(WORDS - 1);
`ifdef LR35902_OAM_DMA_EN
  localparam logic [ADR_W-1:0] LAST_BYTE = ADR_W'(TOTAL - 1);
`endif

`ifdef LR35902_OAM_DMA_EN
  typedef enum logic [1:0] {CLEAR, IDLE, DMA} state_t;
`else
  typedef enum logic [1:0] {CLEAR, IDLE} state_t;
`endif

  state_t            state, state_n;
  logic [ADR_W-1:0]  cnt, cnt_n;

  logic [WORD_W-1:0] mem [WORDS];

  logic [WORD_W-1:0] dout_wide_q;
  logic [LANE_W-1:0] lane_q;

  // Write history: adr/din are captured every cycle write is high so the
  // commit on the falling edge uses the values from the last high cycle.
  logic              wr_hist_p1;
  logic [ADR_W-1:0]  wr_adr_p1;
  logic [7:0]        wr_din_p1;
  logic              commit;

  // Single RAM write port shared by clear, CPU commit and DMA.
  logic              we;
  logic [WIDX_W-1:0] widx;
  logic [LANES-1:0]  wmask;
  logic [WORD_W-1:0] wdata;

  function automatic logic [WIDX_W-1:0] word_of(input logic [ADR_W-1:0] a);
    return WIDX_W'(a / LANES);
  endfunction

  function automatic logic [LANE_W-1:0] lane_of(input logic [ADR_W-1:0] a);
    return LANE_W'(a % LANES);
  endfunction

  function automatic logic in_range(input logic [ADR_W-1:0] a);
    return {1'b0, a} < TOTAL_C;
  endfunction

  // A falling edge outside IDLE is still consumed because the history register always tracks write.
  assign commit = wr_hist_p1 && !bus.write && (state == IDLE) && in_range(wr_adr_p1);

  // Sequencer state and counter; reset always restarts the clear from word 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state and RAM write port selection.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    we      = 1'b0;
    widx    = '0;
    wmask   = '0;
    wdata   = '0;
    case (state)
      CLEAR: begin
        we    = 1'b1;
        widx  = WIDX_W'(cnt);
        wmask = '1;
        if (cnt == LAST_WORD) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      IDLE: begin
        if (commit) begin
          we    = 1'b1;
          widx  = word_of(wr_adr_p1);
          wmask = LANES'(1) << lane_of(wr_adr_p1);
          wdata = {LANES{wr_din_p1}};
        end
`ifdef LR35902_OAM_DMA_EN
        if (dma_start) begin
          state_n = DMA;
          cnt_n   = '0;
        end
`endif
      end
`ifdef LR35902_OAM_DMA_EN
      DMA: begin
        we    = 1'b1;
        widx  = word_of(cnt);
        wmask = LANES'(1) << lane_of(cnt);
        wdata = {LANES{dma_din}};
        if (cnt == LAST_BYTE) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
`endif
      default: begin
        state_n = CLEAR;
        cnt_n   = '0;
      end
    endcase
  end

  // Byte-masked RAM write; contents are only ever zeroed by the clear sequencer.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Registered wide read, read-first against a same-cycle write; all ones when busy or out of range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_wide_q <= '0;
      lane_q      <= '0;
    end else if (bus.read) begin
      lane_q <= lane_of(bus.adr);
      if ((state != IDLE) || !in_range(bus.adr)) dout_wide_q <= '1;
      else                                        dout_wide_q <= mem[word_of(bus.adr)];
    end
  end

  // Write strobe history drives the falling-edge commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_hist_p1 <= 1'b0;
    else       wr_hist_p1 <= bus.write;
  end

  // Capture of the address/data that the next commit will use.
  always_ff @(posedge clk) begin
    if (bus.write) begin
      wr_adr_p1 <= bus.adr;
      wr_din_p1 <= bus.din;
    end
  end

  assign bus.dout_wide = dout_wide_q;
  assign bus.dout      = dout_wide_q[lane_q*8 +: 8];
  assign bus.busy      = (state != IDLE);

`ifdef LR35902_OAM_DMA_EN
  assign dma_adr = (state == DMA) ? cnt : '0;
`endif

endmodule

// File: tb/tb_lr35902_oam_multi.sv
// Directed bench for lr35902_oam_multi at default parameters (160 bytes, 2 lanes).
// A byte model predicts read data; expected results go through a scoreboard queue.
module tb_lr35902_oam_multi;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lr35902_oam_multi_if #(.ADR_W(8), .LANES(2)) bus ();

`ifdef LR35902_OAM_DMA_EN
  logic       dma_start;
  logic [7:0] dma_adr;
  logic [7:0] dma_din;
  assign dma_din = dma_adr ^ 8'h3C;
`endif

  lr35902_oam_multi #(.ENTRIES(40), .ENTRY_BYTES(4), .LANES(2), .ADR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef LR35902_OAM_DMA_EN
    .dma_start (dma_start),
    .dma_adr   (dma_adr),
    .dma_din   (dma_din),
`endif
    .bus       (bus)
  );

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  model [160];
  logic [15:0] exp_wide_q [$];
  logic [7:0]  exp_byte_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 160; i++) model[i] = 8'h00;
  endtask

  // Push the expected response for address a (from the model, or all ones).
  task automatic push_exp(input logic [7:0] a, input bit busy_exp);
    if (busy_exp || a >= 8'd160) begin
      exp_wide_q.push_back(16'hFFFF);
      exp_byte_q.push_back(8'hFF);
    end else begin
      exp_wide_q.push_back({model[{a[7:1], 1'b1}], model[{a[7:1], 1'b0}]});
      exp_byte_q.push_back(model[a]);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [15:0] ew;
    logic [7:0]  eb;
    ew = exp_wide_q.pop_front();
    eb = exp_byte_q.pop_front();
    chk({tag, "_wide"}, 32'(bus.dout_wide), 32'(ew));
    chk({tag, "_byte"}, 32'(bus.dout), 32'(eb));
  endtask

  task automatic rd(input logic [7:0] a, input bit busy_exp, input string tag);
    @(negedge clk);
    bus.adr  = a;
    bus.read = 1'b1;
    push_exp(a, busy_exp);
    @(posedge clk);
    #1;
    bus.read = 1'b0;
    pop_chk(tag);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input int ncyc);
    @(negedge clk);
    bus.adr   = a;
    bus.din   = d;
    bus.write = 1'b1;
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    bus.write = 1'b0;
    bus.adr   = 8'h00;
    bus.din   = 8'h00;
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    bus.adr = 8'h00;
    bus.din = 8'h00;
    bus.read = 1'b0;
    bus.write = 1'b0;
`ifdef LR35902_OAM_DMA_EN
    dma_start = 1'b0;
`endif
    clear_model();

    // Reset state and the initial clear.
    #1 reset = 1'b1;
    #11;
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_wide", 32'(bus.dout_wide), 32'h0000);
    chk("rst_byte", 32'(bus.dout), 32'h00);
    @(negedge clk);
    reset = 1'b0;
    count_busy(n);
    chk("clear_cycles", 32'(n), 32'd80);
    for (int a = 0; a < 160; a++) rd(8'(a), 1'b0, "clear_rd");

    // Three-cycle write pulse; the commit cycle reads the same word read-first.
    @(negedge clk);
    bus.adr = 8'h11;
    bus.din = 8'hA5;
    bus.write = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.write = 1'b0;
    bus.adr = 8'h10;
    bus.din = 8'h00;
    bus.read = 1'b1;
    push_exp(8'h10, 1'b0);
    @(posedge clk);
    #1;
    bus.read = 1'b0;
    pop_chk("read_first");
    model[8'h11] = 8'hA5;
    rd(8'h10, 1'b0, "w11_rd10");
    chk("w11_lit", 32'(bus.dout_wide), 32'hA500);
    rd(8'h11, 1'b0, "w11_rd11");

    // Byte-granular write to the other lane, then read=0 holds the output.
    wr(8'h10, 8'h3C, 1);
    model[8'h10] = 8'h3C;
    rd(8'h11, 1'b0, "lane_rd11");
    repeat (2) @(posedge clk);
    #1;
    chk("hold_wide", 32'(bus.dout_wide), 32'hA53C);
    chk("hold_byte", 32'(bus.dout), 32'hA5);

    // Out-of-range write dropped; out-of-range read gives all ones.
    wr(8'hA0, 8'h55, 1);
    rd(8'hA0, 1'b0, "oor_rdA0");
    rd(8'h9F, 1'b0, "oor_rd9F");
    rd(8'h9E, 1'b0, "oor_rd9E");

    // Write falling during the clear is dropped; reads during busy give all ones.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    repeat (38) @(posedge clk);
    @(negedge clk);
    bus.adr = 8'h04;
    bus.din = 8'h77;
    bus.write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.write = 1'b0;
    bus.adr = 8'h00;
    bus.din = 8'h00;
    @(posedge clk);
    rd(8'h11, 1'b1, "busy_rd");
    count_busy(n);
    chk("clear_remaining", 32'(n), 32'd39);
    rd(8'h04, 1'b0, "drop_rd04");
    rd(8'h05, 1'b0, "drop_rd05");
    rd(8'h11, 1'b0, "cleared_rd11");

    // Reset reasserted mid-clear restarts the full clear.
    wr(8'h9C, 8'h99, 1);
    model[8'h9C] = 8'h99;
    rd(8'h9C, 1'b0, "pre_rd9C");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    repeat (49) @(posedge clk);
    rd(8'h9C, 1'b1, "busy50_rd");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst2_busy", 32'(bus.busy), 32'd1);
    chk("rst2_wide", 32'(bus.dout_wide), 32'h0000);
    chk("rst2_byte", 32'(bus.dout), 32'h00);
    @(negedge clk);
    reset = 1'b0;
    count_busy(n);
    chk("restart_cycles", 32'(n), 32'd80);
    rd(8'h9C, 1'b0, "post_rd9C");
    rd(8'h9D, 1'b0, "post_rd9D");

`ifdef LR35902_OAM_DMA_EN
    // DMA fill: dma_din follows dma_adr; a CPU write and a second dma_start mid-DMA are ignored.
    @(negedge clk);
    dma_start = 1'b1;
    @(posedge clk);
    #1;
    dma_start = 1'b0;
    n = 0;
    while (bus.busy && n < 1000) begin
      chk("dma_adr", 32'(dma_adr), 32'(n));
      if (n == 20) begin
        bus.adr = 8'h05;
        bus.din = 8'hEE;
        bus.write = 1'b1;
      end
      if (n == 22) begin
        bus.write = 1'b0;
        bus.adr = 8'h00;
        bus.din = 8'h00;
      end
      dma_start = (n == 50);
      @(posedge clk);
      #1;
      n++;
    end
    dma_start = 1'b0;
    chk("dma_cycles", 32'(n), 32'd160);
    chk("dma_adr_idle", 32'(dma_adr), 32'h00);
    for (int i = 0; i < 160; i++) model[i] = 8'(i) ^ 8'h3C;
    for (int a = 0; a < 160; a++) rd(8'(a), 1'b0, "dma_rd");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lr35902_oam_multi.md
Name: lr35902_oam_multi

Overview:
Parametrised object attribute memory (OAM) for the PPU, the successor to the fixed 160-byte, 2-byte-wide OAM.
- Entry count, bytes per entry and wide-read lane count are parameters.
- CPU byte read/write port plus a LANES-byte wide read for the sprite fetcher.
- Self-clearing sequencer after reset; optional built-in OAM DMA engine.
- Sits between the CPU bus decoder / DMA unit and the PPU sprite fetch logic.

Parameters:
- ENTRIES, 40, number of objects.
- ENTRY_BYTES, 4, bytes per object.
- LANES, 2, bytes per wide read word; power of two that divides ENTRY_BYTES.
- ADR_W, 8, byte address width. Requires ENTRIES*ENTRY_BYTES <= 2**ADR_W.

Derived values:
- TOTAL = ENTRIES*ENTRY_BYTES (160).
- WORDS = TOTAL/LANES (80).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- adr  in  ADR_W  CPU byte address.
- din  in  8  CPU write data.
- read  in  1  read enable.
- write  in  1  write strobe; commits on falling edge.
- dout  out  8  byte lane selected from dout_wide.
- dout_wide  out  LANES*8  registered wide read word; lane 0 in bits [7:0].
- busy  out  1  clear sequencer (or DMA) active.

Behaviour:
Reset (async, while asserted):
- state=CLEAR, cnt=0, dout_wide=0, lane register=0, busy=1, write-history register=0.
- RAM contents are not reset directly; the clear sequencer zeroes them.

State CLEAR:
- Each clk after reset deasserts, write zeros to word cnt, then cnt+1.
- At cnt==WORDS-1, write that word and go to IDLE.
- busy falls exactly WORDS clocks after reset deassertion (80 at defaults).
- reset asserted mid-clear: restart from cnt=0.

Read (state IDLE, read=1):
- Next clk: dout_wide <= word[adr/LANES]; lane register <= adr mod LANES.
- 1-cycle latency.
- adr >= TOTAL: dout_wide <= all ones.
- read=0: dout_wide holds.

dout:
- Combinational byte (lane register) of dout_wide.
- Tracks the captured lane, not live adr.

Write:
- Registered write-history; commit in the first cycle with write==0 after write==1.
- Commit uses adr/din sampled in the last cycle write was high.
- Byte-granular: only the addressed lane changes.
- Address >= TOTAL: write dropped.

Read and write commit to the same word in the same cycle:
- Read returns old data (read-first).
- Memory takes the new data.

While busy (any state other than IDLE):
- Read: dout_wide <= all ones.
- Write commits dropped silently.
- A falling edge of write during busy is consumed (no deferred commit).

Optional Feature:
Macro: LR35902_OAM_DMA_EN

Enabled — additional ports:
- dma_start in 1.
- dma_adr out ADR_W.
- dma_din in 8.

Enabled — behaviour:
- New state DMA, entered from IDLE on dma_start=1.
- dma_start is ignored in CLEAR and in DMA (no restart).
- In DMA: dma_adr=cnt combinationally.
- Each clk: byte cnt <= dma_din, cnt+1. At cnt==TOTAL-1, write and return to IDLE.
- Duration exactly TOTAL clocks; busy=1 throughout.
- CPU access during DMA is blocked per the busy rules.
- reset during DMA: goes to CLEAR.
- dma_adr = 0 outside DMA.

Disabled:
- dma_* ports are absent.
- No DMA state; dma_start does not exist.

Test Plan:
1. Reset release -> busy high exactly 80 clks, then low. Read of each address 0..159 returns 0x00 in both dout_wide lanes.
2. write pulse 3 clks at adr=0x11, din=0xA5 -> commit in the cycle after write falls. Read adr 0x10 gives dout_wide=0xA500; dout=0x00 with lane 0 captured, 0xA5 for adr 0x11.
3. Write adr=0xA0 (>=TOTAL) din=0x55, then read 0xA0 -> dout_wide=0xFFFF. Read 0x9F -> unchanged 0x0000.
4. Write to adr 0x04 falling during CLEAR (cnt=40) -> dropped: read after busy falls gives 0x00. Read during busy returns 0xFFFF.
5. Reset reasserted at cnt=50, then released -> busy high a full 80 more clks; a word written before reset reads 0x00 afterwards.
6. (DMA_EN) dma_start in IDLE, dma_din = dma_adr^0x3C -> busy 160 clks, dma_adr 0..159. Afterwards byte n reads n^0x3C; a CPU write issued mid-DMA is dropped.
